// File: rtl/ranger_lsu.sv
// Load/store unit between the datapath and a wait-stated word bus (req/ack, watchdog, lane steering).
// Define LSU_MISALIGN_SPLIT_EN to run misaligned H/W accesses as two bus beats instead of trapping.
module ranger_lsu #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [2:0]              funct3_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wd_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_WIDTH-1:0]   rd_o,
    output logic                    err_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [ADDR_WIDTH-3:0]   bus_addr_o,
    output logic [DATA_WIDTH/8-1:0] bus_be_o,
    output logic [DATA_WIDTH-1:0]   bus_wd_o,
    input  logic [DATA_WIDTH-1:0]   bus_rd_i,
    input  logic                    bus_ack_i
);
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("ranger_lsu: DATA_WIDTH must be 32");
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int unsigned LaneW = 2 * DATA_WIDTH;
    typedef enum logic [1:0] {StIdle, StBeat0, StResp, StBeat1} state_e;
`else
    localparam int unsigned LaneW = DATA_WIDTH;
    typedef enum logic [1:0] {StIdle, StBeat0, StResp} state_e;
`endif
    localparam int unsigned LaneBeW = LaneW / 8;
    localparam int unsigned CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rd_q, rd_d;
    logic                    err_q, err_d;
    logic                    we_q;
    logic [2:0]              f3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wd_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic                    split_q;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;
`endif

    logic                    accept, illegal_in, misalign_in, timeout_hit, in_beat1;
    logic [1:0]              off;
    logic [3:0]              mask;
    logic [LaneBeW-1:0]      lane_be;
    logic [LaneW-1:0]        lane_wd, ld_buf;
    logic [DATA_WIDTH-1:0]   ld_sh, ld_ext;
    logic [ADDR_WIDTH-3:0]   word0;

    assign accept      = (state_q == StIdle) && req_i;
    assign illegal_in  = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
    assign misalign_in = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                         ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    assign off     = addr_q[1:0];
    assign mask    = (f3_q[1:0] == 2'b00) ? 4'b0001 : (f3_q[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign lane_be = LaneBeW'(mask) << off;
    assign lane_wd = LaneW'(wd_q) << {off, 3'b000};
    assign word0   = addr_q[ADDR_WIDTH-1:2];

`ifdef LSU_MISALIGN_SPLIT_EN
    assign in_beat1 = (state_q == StBeat1);
    assign ld_buf   = in_beat1 ? {bus_rd_i, lo_q} : {{DATA_WIDTH{1'b0}}, bus_rd_i};
`else
    assign in_beat1 = 1'b0;
    assign ld_buf   = bus_rd_i;
`endif
    assign ld_sh = DATA_WIDTH'(ld_buf >> {off, 3'b000});

    always_comb begin
        ld_ext = ld_sh;
        unique case (f3_q)
            3'b000:  ld_ext = {{(DATA_WIDTH-8){ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_ext = {{(DATA_WIDTH-16){ld_sh[15]}}, ld_sh[15:0]};
            3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_sh[7:0]};
            3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rd_d    = rd_q;
        err_d   = err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        lo_d    = lo_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    rd_d  = '0;
                    err_d = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (illegal_in) begin
`else
                    if (illegal_in || misalign_in) begin
`endif
                        state_d = StResp;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StBeat0;
                    end
                end
            end
            StResp: state_d = StIdle;
            default: begin
                // Ack wins over the watchdog in the cycle the count would expire.
                if (bus_ack_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    lo_d = bus_rd_i;
                    if (split_q && !in_beat1) begin
                        state_d = StBeat1;
                    end else begin
                        state_d = StResp;
                        rd_d    = we_q ? '0 : ld_ext;
                    end
`else
                    state_d = StResp;
                    rd_d    = we_q ? '0 : ld_ext;
`endif
                end else if (timeout_hit) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rd_d    = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    always_comb begin
        busy_o     = (state_q != StIdle);
        done_o     = (state_q == StResp);
        err_o      = done_o && err_q;
        rd_o       = rd_q;
        bus_req_o  = (state_q != StIdle) && (state_q != StResp);
        bus_we_o   = 1'b0;
        bus_addr_o = '0;
        bus_be_o   = '0;
        bus_wd_o   = '0;
        if (bus_req_o) begin
            bus_we_o   = we_q;
            bus_addr_o = in_beat1 ? word0 + 1'b1 : word0;
            bus_be_o   = '1;
            if (we_q) begin
                bus_be_o = in_beat1 ? lane_be[LaneBeW-1 -: 4] : lane_be[3:0];
                bus_wd_o = in_beat1 ? lane_wd[LaneW-1 -: DATA_WIDTH] : lane_wd[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= 1'b0;
            lo_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            lo_q    <= lo_d;
            if (accept) split_q <= misalign_in;
`endif
            if (accept) begin
                we_q   <= we_i;
                f3_q   <= funct3_i;
                addr_q <= addr_i;
                wd_q   <= wd_i;
            end
        end
    end
endmodule

// File: tb/tb_ranger_lsu.sv
// Directed bench for ranger_lsu; built with a 4-cycle watchdog so the timeout case stays short.
module tb_ranger_lsu;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_i, we_i, bus_ack_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wd_i, bus_rd_i;
    logic        busy_o, done_o, err_o, bus_req_o, bus_we_o;
    logic [31:0] rd_o, bus_wd_o;
    logic [29:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    int          total = 0;
    int          bad = 0;

    ranger_lsu #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wd_i(wd_i), .busy_o(busy_o), .done_o(done_o), .rd_o(rd_o),
        .err_o(err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wd_o(bus_wd_o), .bus_rd_i(bus_rd_i), .bus_ack_i(bus_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        req_i = 1'b1; we_i = w; funct3_i = f; addr_i = a; wd_i = d;
        tick();
        req_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000;
        addr_i = '0; wd_i = '0; bus_rd_i = '0; bus_ack_i = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_breq", bus_req_o, 0);
        chk("rst_rd", rd_o, 0);
        chk("rst_err", err_o, 0);
        tick();
        reset_i = 1'b0;
        tick();

        // 1: LW 0x100 with three wait cycles
        start(1'b0, 3'b010, 32'h100, 32'h0);
        chk("t1_breq", bus_req_o, 1);
        chk("t1_addr", bus_addr_o, 30'h40);
        chk("t1_be", bus_be_o, 4'b1111);
        chk("t1_we", bus_we_o, 0);
        chk("t1_busy", busy_o, 1);
        tick(); tick(); tick();
        chk("t1_breq_wait", bus_req_o, 1);
        bus_ack_i = 1'b1; bus_rd_i = 32'hDEADBEEF;
        tick();
        bus_ack_i = 1'b0;
        chk("t1_done", done_o, 1);
        chk("t1_rd", rd_o, 32'hDEADBEEF);
        chk("t1_err", err_o, 0);
        chk("t1_breq_off", bus_req_o, 0);
        tick();
        chk("t1_idle_done", done_o, 0);
        chk("t1_idle_busy", busy_o, 0);
        chk("t1_rd_held", rd_o, 32'hDEADBEEF);

        // 2: LB / LBU at byte 3
        start(1'b0, 3'b000, 32'h103, 32'h0);
        chk("t2_addr", bus_addr_o, 30'h40);
        bus_ack_i = 1'b1; bus_rd_i = 32'h80FFFFFF;
        tick();
        bus_ack_i = 1'b0;
        chk("t2_lb_done", done_o, 1);
        chk("t2_lb_rd", rd_o, 32'hFFFFFF80);
        tick();
        start(1'b0, 3'b100, 32'h103, 32'h0);
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        chk("t2_lbu_rd", rd_o, 32'h00000080);
        tick();

        // 3: SH at 0x102
        start(1'b1, 3'b001, 32'h102, 32'h1234ABCD);
        chk("t3_we", bus_we_o, 1);
        chk("t3_be", bus_be_o, 4'b1100);
        chk("t3_wd", bus_wd_o, 32'hABCD0000);
        chk("t3_addr", bus_addr_o, 30'h40);
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        chk("t3_done", done_o, 1);
        chk("t3_err", err_o, 0);
        tick();

        // 4: misaligned LW 0x1FE
        start(1'b0, 3'b010, 32'h1FE, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("t4_addr0", bus_addr_o, 30'h7F);
        bus_ack_i = 1'b1; bus_rd_i = 32'hAAAA0000;
        tick();
        chk("t4_breq1", bus_req_o, 1);
        chk("t4_addr1", bus_addr_o, 30'h80);
        bus_rd_i = 32'h0000BBBB;
        tick();
        bus_ack_i = 1'b0;
        chk("t4_done", done_o, 1);
        chk("t4_rd", rd_o, 32'hBBBBAAAA);
        chk("t4_err", err_o, 0);
`else
        chk("t4_breq", bus_req_o, 0);
        chk("t4_done", done_o, 1);
        chk("t4_err", err_o, 1);
        chk("t4_rd", rd_o, 0);
`endif
        tick();

        // illegal funct3 goes straight to response
        start(1'b0, 3'b011, 32'h100, 32'h0);
        chk("ill_breq", bus_req_o, 0);
        chk("ill_done", done_o, 1);
        chk("ill_err", err_o, 1);
        tick();

        // 5: watchdog, ack never arrives
        start(1'b0, 3'b010, 32'h200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_breq%0d", i), bus_req_o, 1);
            tick();
        end
        chk("t5_breq_drop", bus_req_o, 0);
        chk("t5_done", done_o, 1);
        chk("t5_err", err_o, 1);
        chk("t5_rd", rd_o, 0);
        tick();

        // 6: async reset mid-beat, then a normal LW
        start(1'b0, 3'b010, 32'h104, 32'h0);
        chk("t6_breq", bus_req_o, 1);
        #2 reset_i = 1'b1;
        #1;
        chk("t6_breq_rst", bus_req_o, 0);
        chk("t6_busy_rst", busy_o, 0);
        reset_i = 1'b0;
        tick();
        start(1'b0, 3'b010, 32'h104, 32'h0);
        chk("t6_addr", bus_addr_o, 30'h41);
        bus_ack_i = 1'b1; bus_rd_i = 32'h12345678;
        tick();
        bus_ack_i = 1'b0;
        chk("t6_done", done_o, 1);
        chk("t6_rd", rd_o, 32'h12345678);
        chk("t6_err", err_o, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
